// File: rtl/npc_pkg.sv
// Shared definitions for the instruction-fetch front end: reset constants and fetch FSM states.
`default_nettype none

package npc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_fetch.sv
// Single-request instruction fetch unit with registered output and redirect/drop handling.
// Optional feature: define IFU_MISALIGN_CHECK_EN to turn misaligned redirects into marker entries.
`default_nettype none

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = npc_pkg::NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic        out_misalign,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    import npc_pkg::ifu_state_t;
    import npc_pkg::IFU_IDLE;
    import npc_pkg::IFU_REQ;
    import npc_pkg::IFU_WAIT;
    import npc_pkg::IFU_HOLD;
    import npc_pkg::pc_next;

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;

    logic [31:0] tgt;
    logic        tgt_mis;
    logic        pc_mis;
    logic        marker_go;
    logic [31:0] marker_addr;
    logic        req_fire;

`ifdef IFU_MISALIGN_CHECK_EN
    logic        mis_q, mis_d;
    assign tgt     = redirect_pc;
    assign tgt_mis = (redirect_pc[1:0] != 2'b00);
    assign pc_mis  = (pc_q[1:0] != 2'b00);
`else
    // Without the check, targets are silently word-aligned.
    assign tgt     = {redirect_pc[31:2], 2'b00};
    assign tgt_mis = 1'b0;
    assign pc_mis  = 1'b0;
`endif

    assign imem_req_valid = (state_q == IFU_REQ) && !pc_mis;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        marker_go   = 1'b0;
        marker_addr = tgt;
`ifdef IFU_MISALIGN_CHECK_EN
        mis_d       = mis_q;
`endif

        case (state_q)
            IFU_IDLE: begin
                state_d = IFU_REQ;
            end
            IFU_REQ: begin
                if (redirect_valid) begin
                    pc_d = tgt;
                    if (tgt_mis) begin
                        marker_go = 1'b1;
                    end else if (req_fire) begin
                        // The accepted request targets the old PC; its response must be dropped.
                        state_d = IFU_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (pc_mis) begin
                    marker_go   = 1'b1;
                    marker_addr = pc_q;
                end else if (req_fire) begin
                    state_d = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    pc_d = tgt;
                    if (imem_rsp_valid) begin
                        drop_d = 1'b0;
                        if (tgt_mis) begin
                            marker_go = 1'b1;
                        end else begin
                            state_d = IFU_REQ;
                        end
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_inst_d  = imem_rsp_inst;
                        pc_d        = pc_next(pc_q);
                        state_d     = IFU_HOLD;
`ifdef IFU_MISALIGN_CHECK_EN
                        mis_d       = 1'b0;
`endif
                    end
                end
            end
            IFU_HOLD: begin
                if (redirect_valid) begin
                    pc_d        = tgt;
                    out_valid_d = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
                    mis_d       = 1'b0;
`endif
                    if (tgt_mis) begin
                        marker_go = 1'b1;
                    end else begin
                        state_d = IFU_REQ;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IFU_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
                    mis_d       = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IFU_IDLE;
            end
        endcase

        // A misaligned target becomes a NOP marker entry instead of a memory request.
        if (marker_go) begin
            state_d     = IFU_HOLD;
            out_valid_d = 1'b1;
            out_pc_d    = marker_addr;
            out_inst_d  = NOP_INST;
            pc_d        = pc_next(marker_addr);
            drop_d      = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            mis_d       = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IFU_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_inst_q  <= NOP_INST;
`ifdef IFU_MISALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
`ifdef IFU_MISALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
`ifdef IFU_MISALIGN_CHECK_EN
    assign out_misalign = mis_q;
`endif

endmodule

`default_nettype wire
